// File: rtl/program_counter_stack.sv
// SAP-1 style program counter with count/jump/call/return and a hardware return-address stack.
// Optional build macro PC_TRISTATE_EN: Out floats to 'z when Ep is low (default build drives 0).
module program_counter_stack #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                             CLK,
    input  logic                             CLR_n,
    input  logic                             Cp,
    input  logic                             Ej,
    input  logic                             Ec,
    input  logic                             Er,
    input  logic                             Ep,
    input  logic [ADDR_W-1:0]                Addr,
    output logic [ADDR_W-1:0]                Out,
    output logic [ADDR_W-1:0]                Pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] Level,
    output logic                             Full,
    output logic                             Empty,
    output logic                             Err
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic              err;
    logic              err_nxt;
    logic              push;
    logic              is_full;
    logic              is_empty;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    assign pc_inc   = pc + ADDR_W'(1);
    assign is_full  = (level == LVL_W'(STACK_DEPTH));
    assign is_empty = (level == '0);

    // Next-state: one action per cycle, priority Er > Ec > Ej > Cp.
    always_comb begin
        pc_nxt    = pc;
        level_nxt = level;
        err_nxt   = err;
        push      = 1'b0;
        if (Er) begin
            if (is_empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt    = stack[IDX_W'(level - LVL_W'(1))];
                level_nxt = level - LVL_W'(1);
            end
        end else if (Ec) begin
            if (is_full) begin
                err_nxt = 1'b1;
            end else begin
                push      = 1'b1;
                pc_nxt    = Addr;
                level_nxt = level + LVL_W'(1);
            end
        end else if (Ej) begin
            pc_nxt = Addr;
        end else if (Cp) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            pc    <= ADDR_W'(RESET_ADDR);
            level <= '0;
            err   <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            level <= level_nxt;
            err   <= err_nxt;
        end
    end

    // Stack contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            stack[IDX_W'(level)] <= pc_inc;
        end
    end

    assign Pc    = pc;
    assign Level = level;
    assign Full  = is_full;
    assign Empty = is_empty;
    assign Err   = err;

`ifdef PC_TRISTATE_EN
    assign Out = Ep ? pc : {ADDR_W{1'bz}};
`else
    assign Out = Ep ? pc : '0;
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed self-checking bench for program_counter_stack (ADDR_W=4, STACK_DEPTH=4, default build).
module tb_program_counter_stack;

    logic       CLK;
    logic       CLR_n;
    logic       Cp, Ej, Ec, Er, Ep;
    logic [3:0] Addr;
    logic [3:0] Out;
    logic [3:0] Pc;
    logic [2:0] Level;
    logic       Full, Empty, Err;

    int n_assert = 0;
    int n_fail   = 0;

    program_counter_stack #(
        .ADDR_W(4),
        .STACK_DEPTH(4),
        .RESET_ADDR(0)
    ) dut (
        .CLK(CLK),
        .CLR_n(CLR_n),
        .Cp(Cp),
        .Ej(Ej),
        .Ec(Ec),
        .Er(Er),
        .Ep(Ep),
        .Addr(Addr),
        .Out(Out),
        .Pc(Pc),
        .Level(Level),
        .Full(Full),
        .Empty(Empty),
        .Err(Err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply strobes for exactly one rising edge, then sample 1 time unit later.
    task automatic step(input logic er, input logic ec, input logic ej, input logic cp,
                        input logic [3:0] a);
        Er = er; Ec = ec; Ej = ej; Cp = cp; Addr = a;
        @(posedge CLK);
        #1;
        Er = 1'b0; Ec = 1'b0; Ej = 1'b0; Cp = 1'b0; Addr = 4'd0;
    endtask

    task automatic state(input string tag, input logic [3:0] pc, input logic [2:0] lvl,
                         input logic err);
        chk({tag, "_pc"},    8'(Pc),    8'(pc));
        chk({tag, "_level"}, 8'(Level), 8'(lvl));
        chk({tag, "_err"},   8'(Err),   8'(err));
    endtask

    initial begin
        CLR_n = 1'b0; Ep = 1'b1;
        Er = 1'b0; Ec = 1'b0; Ej = 1'b0; Cp = 1'b0; Addr = 4'd0;
        #12;
        state("reset", 4'd0, 3'd0, 1'b0);
        chk("reset_empty", 8'(Empty), 8'd1);
        chk("reset_full",  8'(Full),  8'd0);
        chk("reset_out",   8'(Out),   8'd0);
        @(negedge CLK);
        CLR_n = 1'b1;
        @(posedge CLK);
        #1;

        // Count 17 cycles: 1..15, 0, 1
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
            chk($sformatf("count_%0d", i), 8'(Pc), 8'((i + 1) % 16));
        end
        chk("count_err", 8'(Err), 8'd0);

        // Jump to 3, call 9, return to 4
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        chk("jump_pc", 8'(Pc), 8'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
        state("call", 4'd9, 3'd1, 1'b0);
        chk("call_empty", 8'(Empty), 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        state("ret", 4'd4, 3'd0, 1'b0);
        chk("ret_empty", 8'(Empty), 8'd1);

        // Four nested calls from pc=4: pushes 5,11,12,13
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd13);
        state("nest4", 4'd13, 3'd4, 1'b0);
        chk("nest4_full", 8'(Full), 8'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        state("overflow", 4'd13, 3'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        state("pop1", 4'd13, 3'd3, 1'b1);
        chk("pop1_full", 8'(Full), 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("pop2_pc", 8'(Pc), 8'd12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("pop3_pc", 8'(Pc), 8'd11);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        state("pop4", 4'd5, 3'd0, 1'b1);

        // Async reset mid-cycle clears Err immediately
        CLR_n = 1'b0;
        #1;
        state("areset", 4'd0, 3'd0, 1'b0);
        #1;
        CLR_n = 1'b1;
        @(posedge CLK);
        #1;

        // Underflow: pc holds, Err sticks through later activity
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        state("underflow", 4'd0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        state("err_sticky", 4'd2, 3'd0, 1'b1);

        // Level=1 with top=7, then all strobes: return wins
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd14);
        state("prio_setup", 4'd14, 3'd1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        state("prio_ret", 4'd7, 3'd0, 1'b1);
        // Call beats jump and count; jump beats count
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        state("prio_call", 4'd5, 3'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        state("prio_jump", 4'd9, 3'd1, 1'b1);

        // Output enable gating is combinational; Pc ignores Ep
        Ep = 1'b0;
        #1;
        chk("ep0_out", 8'(Out), 8'd0);
        chk("ep0_pc",  8'(Pc),  8'd9);
        Ep = 1'b1;
        #1;
        chk("ep1_out", 8'(Out), 8'd9);

        // Reset mid-call sequence discards the stack
        CLR_n = 1'b0;
        #1;
        state("areset_call", 4'd0, 3'd0, 1'b0);
        chk("areset_call_empty", 8'(Empty), 8'd1);
        #1;
        CLR_n = 1'b1;
        @(posedge CLK);
        #1;

        // Return address wraps: call from 15 pushes 0
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        state("wrap_call", 4'd1, 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        state("wrap_ret", 4'd0, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
